// File: rtl/ex_muldiv_unit.sv
// Execute-stage multi-cycle helper: restoring DIV/DIVU and two-cycle MADD/MSUB family on HI/LO.
// Holds the pipeline through stallreq until the result is presented with ready.
//
// state    | meaning
// IDLE     | waiting for a multi-cycle op from EX
// DIV_ZERO | divisor was zero, quotient and remainder forced to 0
// DIV_ON   | one restoring step per cycle, DATA_W cycles in total
// DIV_END  | sign-corrected quotient/remainder presented, ready=1
// MAC_END  | HI/LO +/- registered product presented, ready=1
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              annul,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo,
  output logic              ready,
  output logic              stallreq
);

  localparam logic [2:0] OP_DIV   = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MADDU = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MSUBU = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    DIV_ZERO,
    DIV_ON,
    DIV_END,
    MAC_END
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   dq;
  logic [DATA_W-1:0]   dvs;
  logic                neg_q;
  logic                neg_r;
  logic [2*DATA_W-1:0] prod;
  logic                mac_sub;

  logic                is_div;
  logic                is_mac;
  logic                op_signed;
  logic                accept;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] mul_b;
  logic [DATA_W:0]     step_ext;
  logic [DATA_W+1:0]   step_diff;
  logic                step_ok;
  logic                last_step;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;
  logic [2*DATA_W-1:0] mac_sum;

  always_comb begin
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_mac    = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    op_signed = (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    accept    = (state == IDLE) && start && (is_div || is_mac);

    abs_a = (op_signed && opa[DATA_W-1]) ? (~opa + 1'b1) : opa;
    abs_b = (op_signed && opb[DATA_W-1]) ? (~opb + 1'b1) : opb;

    // Sign- or zero-extend to full product width; the low 2*DATA_W bits are exact either way.
    mul_a = {{DATA_W{op_signed & opa[DATA_W-1]}}, opa};
    mul_b = {{DATA_W{op_signed & opb[DATA_W-1]}}, opb};

    step_ext  = {rem, dq[DATA_W-1]};
    step_diff = {1'b0, step_ext} - {2'b00, dvs};
    step_ok   = ~step_diff[DATA_W+1];
    last_step = (cnt == CNT_W'(DATA_W-1));
  end

  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    if (annul) begin
      state_next = IDLE;
    end else begin
      stallreq = accept || (state == DIV_ON) || (state == DIV_ZERO);
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_div) state_next = (opb == '0) ? DIV_ZERO : DIV_ON;
            else        state_next = MAC_END;
          end
        end
        DIV_ZERO: state_next = DIV_END;
        DIV_ON:   if (last_step) state_next = DIV_END;
        DIV_END:  state_next = IDLE;
        MAC_END:  state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || annul) begin
      cnt     <= '0;
      rem     <= '0;
      dq      <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      prod    <= '0;
      mac_sub <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_div) begin
            dq    <= abs_a;
            dvs   <= abs_b;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= op_signed && (opa[DATA_W-1] ^ opb[DATA_W-1]);
            neg_r <= op_signed && opa[DATA_W-1];
          end else if (accept && is_mac) begin
            prod    <= mul_a * mul_b;
            mac_sub <= (op == OP_MSUB) || (op == OP_MSUBU);
          end
        end
        DIV_ZERO: begin
          rem <= '0;
          dq  <= '0;
        end
        DIV_ON: begin
          // dq shifts the dividend out at the top and the quotient in at the bottom.
          if (step_ok) rem <= step_diff[DATA_W-1:0];
          else         rem <= step_ext[DATA_W-1:0];
          dq  <= {dq[DATA_W-2:0], step_ok};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_fix     = neg_q ? (~dq + 1'b1) : dq;
    r_fix     = neg_r ? (~rem + 1'b1) : rem;
    mac_sum   = mac_sub ? ({hi_i, lo_i} - prod) : ({hi_i, lo_i} + prod);
    ready     = 1'b0;
    result_hi = '0;
    result_lo = '0;
    case (state)
      DIV_END: begin
        ready     = 1'b1;
        result_hi = r_fix;
        result_lo = q_fix;
      end
      MAC_END: begin
        ready                  = 1'b1;
        {result_hi, result_lo} = mac_sum;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized bench for ex_muldiv_unit; results and latencies come from a plain-arithmetic model.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [W-1:0] hi_i;
  logic [W-1:0] lo_i;
  logic         annul;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
  logic         ready;
  logic         stallreq;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .hi_i(hi_i), .lo_i(lo_i), .annul(annul), .result_hi(result_hi),
    .result_lo(result_lo), .ready(ready), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {h, l};
    p   = '0;
    case (o)
      3'd1: begin
        if (b == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd2: begin
        if (b == 0) return 64'd0;
        return {a % b, a / b};
      end
      3'd3, 3'd5: p = 64'(sa * sb);
      3'd4, 3'd6: p = {32'd0, a} * {32'd0, b};
      default: return 64'd0;
    endcase
    return (o == 3'd3 || o == 3'd4) ? acc + p : acc - p;
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] b);
    if (o == 3'd1 || o == 3'd2) return (b == 0) ? 2 : W + 1;
    if (o >= 3'd3 && o <= 3'd6) return 1;
    return 0;
  endfunction

  // Issues one op at the next cycle and follows it to its ready cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l, input bit hold,
                        input string tag);
    int          lat;
    logic [63:0] exp;
    lat = ref_latency(o, b);
    exp = ref_result(o, a, b, h, l);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; hi_i = h; lo_i = l;
    #1;
    check_eq({tag, " stall@t"}, 64'(stallreq), 64'(lat != 0));
    check_eq({tag, " ready@t"}, 64'(ready), 64'd0);
    if (lat == 0) begin
      repeat (2) begin
        @(negedge clk);
        #1;
        check_eq({tag, " none stall"}, 64'(stallreq), 64'd0);
        check_eq({tag, " none ready"}, 64'(ready), 64'd0);
      end
      start = 1'b0;
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      opa = $urandom;
      opb = $urandom;
      op  = 3'($urandom);
      #1;
      if (c < lat) begin
        if (stallreq !== 1'b1 || ready !== 1'b0)
          check_eq({tag, " busy stall/ready"}, {62'd0, stallreq, ready}, 64'b10);
      end else begin
        check_eq({tag, " ready"}, 64'(ready), 64'd1);
        check_eq({tag, " stall@ready"}, 64'(stallreq), 64'd0);
        check_eq({tag, " result"}, {result_hi, result_lo}, exp);
      end
    end
    if (!hold) start = 1'b0;
  endtask

  // Starts a DIV and kills it at cycle t+at by annul or rst.
  task automatic abort_div(input int at, input bit use_rst, input string tag);
    int pulses;
    @(negedge clk);
    start = 1'b1; op = 3'd1; opa = 32'd100; opb = 32'd3;
    for (int c = 1; c <= at; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == at) begin
        if (use_rst) rst = 1'b1;
        else         annul = 1'b1;
        #1;
        if (!use_rst) check_eq({tag, " stall@annul"}, 64'(stallreq), 64'd0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    annul = 1'b0;
    #1;
    check_eq({tag, " outputs after"}, {result_hi, result_lo, 30'd0, ready, stallreq}, 96'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (ready) pulses++;
    end
    check_eq({tag, " no ready pulse"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = '0;
    opa = '0; opb = '0; hi_i = '0; lo_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset outputs", {result_hi, result_lo, 30'd0, ready, stallreq}, 96'd0);
    rst = 1'b0;

    run_op(3'd1, 32'd7, 32'hFFFF_FFFE, 0, 0, 1'b0, "div 7/-2");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h10, 0, 0, 1'b0, "divu");
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, "div overflow");
    run_op(3'd1, 32'd1234, 32'd0, 0, 0, 1'b0, "div by zero");
    run_op(3'd2, 32'd5, 32'd0, 0, 0, 1'b0, "divu by zero");
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 1'b0, "madd");
    run_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, "msubu");
    run_op(3'd0, 32'd9, 32'd3, 0, 0, 1'b0, "op none");
    run_op(3'd7, 32'd9, 32'd3, 0, 0, 1'b0, "op 7");
    abort_div(10, 1'b0, "annul");
    run_op(3'd4, 32'd3, 32'd5, 32'd1, 32'd2, 1'b0, "maddu after annul");
    abort_div(5, 1'b1, "rst");
    run_op(3'd5, 32'hFFFF_FFFD, 32'd4, 32'd0, 32'd0, 1'b0, "msub after rst");
    run_op(3'd1, 32'hFFFF_FF9C, 32'd7, 0, 0, 1'b1, "b2b first");
    run_op(3'd1, 32'd1000, 32'hFFFF_FFF9, 0, 0, 1'b0, "b2b second");

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      run_op(o, a, b, $urandom, $urandom, 1'($urandom), $sformatf("rand%0d op%0d", i, o));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Multi-cycle arithmetic helper for the execute stage. It sits directly downstream of the ID/EX pipeline register and consumes the registered operation, operand 1 and operand 2.
- Executes DIV/DIVU as a 32-step restoring divider.
- Executes MADD/MADDU/MSUB/MSUBU as a two-cycle multiply-accumulate on HI/LO.
- Raises a stall request to the pipeline controller until its result is ready.

Parameters:
DATA_W, 32, operand width. HI/LO result width equals DATA_W.
CNT_W, 6, width of the division step counter. Must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  clock
rst  in  1  reset. Synchronous, active-high; clock clk.
start  in  1  EX instruction requests a multi-cycle operation
op  in  3  0 NONE, 1 DIV, 2 DIVU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 treated as NONE
opa  in  DATA_W  operand 1 (dividend / multiplicand)
opb  in  DATA_W  operand 2 (divisor / multiplier)
hi_i  in  DATA_W  current HI, already forwarded by EX
lo_i  in  DATA_W  current LO, already forwarded by EX
annul  in  1  flush: abandon the current operation
result_hi  out  DATA_W  HI result; valid only while ready=1
result_lo  out  DATA_W  LO result; valid only while ready=1
ready  out  1  result valid this cycle
stallreq  out  1  hold the pipeline (feeds controller stall bit for EX)

Behaviour:
- States: IDLE, DIV_ZERO, DIV_ON, DIV_END, MAC_END.
- Reset: state=IDLE; counter, remainder/quotient and product registers =0; ready=0; result_hi=result_lo=0. rst has priority over annul and start.
- annul=1 (not in reset): next state IDLE, internal registers cleared. stallreq forced 0 in that cycle.
- accept = state==IDLE && start && op in 1..6.
- stallreq (combinational) = accept || state==DIV_ON || state==DIV_ZERO. It is 0 in DIV_END and MAC_END.
- ready = state==DIV_END || state==MAC_END (Moore decode).
- IDLE:
  - DIV/DIVU with opb==0 -> DIV_ZERO.
  - DIV/DIVU with opb!=0 -> DIV_ON. Latch |opa| and |opb| (raw values for DIVU), latch the sign flags, counter=0.
  - MADD family -> MAC_END. Register the 2*DATA_W-bit product (signed for MADD/MSUB, unsigned for MADDU/MSUBU) and register the op.
- DIV_ZERO: quotient=remainder=0 -> DIV_END next cycle.
- DIV_ON: each cycle compute partial = {rem,next dividend bit} - divisor.
  - Non-negative: keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - counter++. When counter reaches DATA_W-1 the step completes and the state goes to DIV_END.
  - Exactly DATA_W cycles are spent in DIV_ON.
- DIV_END: result_lo = quotient, result_hi = remainder.
  - Signed op: negate the quotient if sign(opa)^sign(opb); negate the remainder if sign(opa).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
  - Next state is IDLE unconditionally.
- MAC_END: {result_hi,result_lo} = {hi_i,lo_i} + product (MADD/MADDU) or - product (MSUB/MSUBU), modulo 2^(2*DATA_W). Computed combinationally from the registered product and the current hi_i/lo_i. Next state IDLE.
- Latency, with accept at cycle t:
  - DIV: ready at t+DATA_W+1.
  - Divide by zero: ready at t+2.
  - MAC: ready at t+1.
  - stallreq=1 on every cycle from t up to, but not including, the ready cycle.
- Back-to-back: the cycle after a ready cycle is IDLE. A new start there is accepted normally. start held high during ready does not re-trigger.
- Operands and op are sampled only on accept. Later changes to opa/opb/op are ignored until IDLE.
- start with op NONE/7: no state change, stallreq=0.

Test Plan:
- DIV opa=7, opb=0xFFFFFFFE (-2) -> stallreq high 33 cycles (t..t+32), ready at t+33, LO=0xFFFFFFFD, HI=1.
- DIVU opa=0xFFFFFFFF, opb=0x10 -> LO=0x0FFFFFFF, HI=0xF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV opb=0 -> stallreq high at t and t+1, ready at t+2, HI=LO=0.
- MADD hi_i=0, lo_i=1, opa=0xFFFFFFFF, opb=2 -> at t+1 ready=1, {HI,LO}=0xFFFFFFFF_FFFFFFFF; MSUBU hi=0,lo=0, opa=opb=0xFFFFFFFF -> {HI,LO}=0x00000001_FFFFFFFF (mod 2^64 of -(2^32-1)^2).
- annul asserted at cycle t+10 of a DIV -> stallreq 0 that cycle, state IDLE at t+11, no ready pulse; rst at t+5 likewise -> all outputs 0 next cycle.
- Two consecutive DIVs (start held high) -> first ready at t+33, second accepted at t+34, second ready at t+67 with its own correct result.
